dct_share_arb: RTL and testbench

DCT_SHARE_ARB -- requirements
Module: dct_share_arb

---
 rtl/dct_share_arb.sv | 138 +++++++++++++
 tb/tb_dct_share_arb.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_share_arb.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | dct_share_arb: two-port block arbiter sharing one 4-point DCT core    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module dct_share_arb #(
    parameter int DATA_W       = 8,
    parameter int OUT_W        = 16,
    parameter int ROWS_PER_BLK = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s0_valid,
    output logic                s0_ready,
    input  logic [4*DATA_W-1:0] s0_x,
    input  logic                s1_valid,
    output logic                s1_ready,
    input  logic [4*DATA_W-1:0] s1_x,
    output logic [4*DATA_W-1:0] core_x,
    input  logic [4*OUT_W-1:0]  core_y,
    output logic                m0_valid,
    input  logic                m0_ready,
    output logic [4*OUT_W-1:0]  m0_y,
    output logic                m0_last,
    output logic                m1_valid,
    input  logic                m1_ready,
    output logic [4*OUT_W-1:0]  m1_y,
    output logic                m1_last,
    output logic                busy
);

    localparam int CNT_W = (ROWS_PER_BLK > 1) ? $clog2(ROWS_PER_BLK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROWS_PER_BLK - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t           state;
    logic             gnt;
    logic             rr;
    logic             v1;
    logic             p1;
    logic             l1;
    logic [CNT_W-1:0] row_cnt;

    logic out_free;
    logic adv;
    logic take;
    logic acc;
    logic is_last;

    // Stage 1 drains into the output register of the port that owns its row,
    // which can differ from the current grant right after a block boundary.
    assign out_free = p1 ? (!m1_valid || m1_ready) : (!m0_valid || m0_ready);
    assign adv      = v1 && out_free;
    assign take     = (state == RUN) && (!v1 || adv);
    assign s0_ready = take && !gnt;
    assign s1_ready = take && gnt;
    assign acc      = gnt ? (s1_valid && s1_ready) : (s0_valid && s0_ready);
    assign is_last  = (row_cnt == LAST_CNT);
    assign busy     = (state != IDLE) || v1 || m0_valid || m1_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= 1'b0;
            rr       <= 1'b0;
            row_cnt  <= '0;
            v1       <= 1'b0;
            p1       <= 1'b0;
            l1       <= 1'b0;
            core_x   <= '0;
            m0_valid <= 1'b0;
            m0_y     <= '0;
            m0_last  <= 1'b0;
            m1_valid <= 1'b0;
            m1_y     <= '0;
            m1_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s0_valid || s1_valid) begin
                        gnt   <= (s0_valid && s1_valid) ? rr : s1_valid;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    row_cnt <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    if (acc) begin
                        row_cnt <= row_cnt + 1'b1;
                        if (is_last) begin
                            rr    <= ~gnt;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (acc) begin
                core_x <= gnt ? s1_x : s0_x;
                l1     <= is_last;
                p1     <= gnt;
                v1     <= 1'b1;
            end else if (adv) begin
                v1 <= 1'b0;
            end

            // A load takes priority over a pop so a same-edge pop+refill stays valid.
            if (adv && !p1) begin
                m0_valid <= 1'b1;
                m0_y     <= core_y;
                m0_last  <= l1;
            end else if (m0_valid && m0_ready) begin
                m0_valid <= 1'b0;
                m0_last  <= 1'b0;
            end

            if (adv && p1) begin
                m1_valid <= 1'b1;
                m1_y     <= core_y;
                m1_last  <= l1;
            end else if (m1_valid && m1_ready) begin
                m1_valid <= 1'b0;
                m1_last  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dct_share_arb.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_dct_share_arb: scoreboard bench for the shared DCT arbiter         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_dct_share_arb;

    localparam int DW  = 8;
    localparam int OW  = 16;
    localparam int RPB = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            s0_valid = 1'b0, s1_valid = 1'b0;
    logic            s0_ready, s1_ready;
    logic [4*DW-1:0] s0_x = '0, s1_x = '0;
    logic [4*DW-1:0] core_x;
    logic [4*OW-1:0] core_y;
    logic            m0_valid, m1_valid, m0_last, m1_last, busy;
    logic            m0_ready = 1'b1, m1_ready = 1'b1;
    logic [4*OW-1:0] m0_y, m1_y;

    typedef struct {
        logic [4*OW-1:0] y;
        bit              last;
        int              cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   order[$];
    int   checks = 0, failures = 0;
    int   cyc = 0, test = 0, blk_cnt = 0, owner = 0, last_hs = -100, gap_base = 0;
    int   acc_cnt[2] = '{0, 0};
    int   pop_cnt[2] = '{0, 0};
    int   nlast0 = 0;
    int   sent[2]  = '{0, 0};
    int   total[2] = '{0, 0};
    bit   en[2]    = '{0, 0};
    bit   hs[2]    = '{0, 0};
    bit   lat_on = 0, fixed_x = 0;

    always #5 clk = ~clk;

    // Reference core: y0 = sum, y1 = x0 - x3, y2 = x1 + x2, y3 = x3.
    function automatic logic [4*OW-1:0] core_f(input logic [4*DW-1:0] x);
        logic [OW-1:0] a, b, c, d;
        a = OW'(x[DW-1:0]);
        b = OW'(x[2*DW-1:DW]);
        c = OW'(x[3*DW-1:2*DW]);
        d = OW'(x[4*DW-1:3*DW]);
        return {d, OW'(b + c), OW'(a - d), OW'(a + b + c + d)};
    endfunction

    function automatic logic [4*DW-1:0] mk(input int port, input int seq);
        if (fixed_x) return {8'd40, 8'd30, 8'd20, 8'd10};
        return {8'h55, 8'(seq * 3), 8'(port), 8'(seq)};
    endfunction

    assign core_y = core_f(core_x);

    dct_share_arb #(.DATA_W(DW), .OUT_W(OW), .ROWS_PER_BLK(RPB)) dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_x(s0_x),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_x(s1_x),
        .core_x(core_x), .core_y(core_y),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_y(m0_y), .m0_last(m0_last),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_y(m1_y), .m1_last(m1_last),
        .busy(busy)
    );

    // Row sources: each port streams rows until sent reaches total.
    always @(posedge clk) begin
        #1;
        for (int p = 0; p < 2; p++) if (hs[p]) sent[p]++;
        s0_valid = en[0] && (sent[0] < total[0]);
        s1_valid = en[1] && (sent[1] < total[1]);
        s0_x     = mk(0, sent[0]);
        s1_x     = mk(1, sent[1]);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic model_step();
        exp_t            e;
        logic [4*DW-1:0] x;
        int              gap;
        cyc++;
        hs[0] = 0;
        hs[1] = 0;
        if (rst) begin
            q0.delete();
            q1.delete();
            blk_cnt = 0;
            last_hs = -100;
            return;
        end
        hs[0] = s0_valid && s0_ready;
        hs[1] = s1_valid && s1_ready;
        chk("ready_exclusive", s0_ready && s1_ready, 0);
        if (test == 1) chk("t1_s1_ready_low", s1_ready, 0);
        for (int i = 0; i < 2; i++) begin
            if (hs[i]) begin
                x = (i == 1) ? s1_x : s0_x;
                if (blk_cnt == 0) begin
                    if (test == 2 && order.size() > gap_base) begin
                        gap = cyc - last_hs - 1;
                        checks++;
                        if (gap < 1 || gap > 2) begin
                            failures++;
                            $display("FAIL t2_grant_gap actual=%0d required=1..2", gap);
                        end
                    end
                    order.push_back(i);
                    owner = i;
                end else begin
                    chk("no_interleave", i, owner);
                end
                e.y    = core_f(x);
                e.last = (blk_cnt == RPB - 1);
                e.cyc  = cyc;
                blk_cnt = e.last ? 0 : blk_cnt + 1;
                if (i == 0) q0.push_back(e);
                else        q1.push_back(e);
                acc_cnt[i]++;
                last_hs = cyc;
            end
        end
        if (m0_valid && m0_ready) begin
            if (q0.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL m0_unexpected actual=valid required=no_row");
            end else begin
                e = q0.pop_front();
                chk("m0_y", m0_y, e.y);
                chk("m0_last", m0_last, e.last);
                if (lat_on) chk("m0_latency", cyc - e.cyc, 2);
                if (test == 1 && pop_cnt[0] == 0) chk("t1_y0_literal", m0_y[15:0], 100);
                if (m0_last) nlast0++;
            end
            pop_cnt[0]++;
        end
        if (m1_valid && m1_ready) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL m1_unexpected actual=valid required=no_row");
            end else begin
                e = q1.pop_front();
                chk("m1_y", m1_y, e.y);
                chk("m1_last", m1_last, e.last);
            end
            pop_cnt[1]++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        #2;
    endtask

    task automatic wait_acc(input int p, input int target, input string name);
        int n = 0;
        while (acc_cnt[p] < target && n < 300) begin tick(); n++; end
        checks++;
        if (acc_cnt[p] < target) begin
            failures++;
            $display("FAIL %s timeout accepted=%0d required=%0d", name, acc_cnt[p], target);
        end
    endtask

    task automatic wait_pop(input int p, input int target, input string name);
        int n = 0;
        while (pop_cnt[p] < target && n < 300) begin tick(); n++; end
        checks++;
        if (pop_cnt[p] < target) begin
            failures++;
            $display("FAIL %s timeout popped=%0d required=%0d", name, pop_cnt[p], target);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || busy) && n < 300) begin tick(); n++; end
        checks++;
        if (q0.size() != 0 || q1.size() != 0 || busy) begin
            failures++;
            $display("FAIL %s timeout pending=%0d busy=%0b required=0", name, q0.size() + q1.size(), busy);
        end
    endtask

    initial begin
        int b0, b1, pb0, h, ostart;
        tick(); tick(); tick();
        rst = 1'b0;

        chk("rst_m0_valid", m0_valid, 0);
        chk("rst_m1_valid", m1_valid, 0);
        chk("rst_m0_last", m0_last, 0);
        chk("rst_m1_last", m1_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s0_ready", s0_ready, 0);
        chk("rst_s1_ready", s1_ready, 0);
        chk("rst_core_x", core_x, 0);
        chk("rst_m0_y", m0_y, 0);
        chk("rst_m1_y", m1_y, 0);

        // Single port 0 block with identical rows.
        test = 1; lat_on = 1; fixed_x = 1;
        en[0] = 1; en[1] = 1;
        total[0] = sent[0] + 4;
        wait_acc(0, acc_cnt[0] + 4, "t1_accept");
        wait_drain("t1_drain");
        chk("t1_last_count", nlast0, 1);
        chk("t1_pop_count", pop_cnt[0], 4);
        chk("t1_core_x_hold", core_x, 32'h281E140A);
        test = 0; lat_on = 0; fixed_x = 0;

        // Both ports requesting from reset: blocks alternate starting at port 0.
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        test = 2; gap_base = order.size(); ostart = order.size();
        b0 = acc_cnt[0]; b1 = acc_cnt[1];
        total[0] = sent[0] + 8; total[1] = sent[1] + 8;
        wait_acc(0, b0 + 8, "t2_acc0");
        wait_acc(1, b1 + 8, "t2_acc1");
        wait_drain("t2_drain");
        chk("t2_block_count", order.size() - ostart, 4);
        for (int i = 0; i < 4; i++)
            if (ostart + i < order.size()) chk("t2_grant_order", order[ostart + i], i % 2);
        test = 0;

        // Output backpressure on port 0 mid-block.
        test = 3; b0 = acc_cnt[0];
        total[0] = sent[0] + 4;
        wait_acc(0, b0 + 2, "t3_acc_pre");
        @(posedge clk); #1; m0_ready = 1'b0;
        tick(); tick(); tick();
        chk("t3_s0_ready_drop", s0_ready, 0);
        chk("t3_m0_valid_held", m0_valid, 1);
        h = acc_cnt[0];
        tick(); tick();
        chk("t3_no_accept_in_stall", acc_cnt[0], h);
        @(posedge clk); #1; m0_ready = 1'b1;
        wait_acc(0, b0 + 4, "t3_acc_post");
        wait_drain("t3_drain");
        test = 0;

        // Port 1 output stalled on its last row while port 0 runs a block.
        test = 4; b1 = acc_cnt[1];
        total[1] = sent[1] + 4;
        wait_acc(1, b1 + 4, "t4_acc1");
        tick();
        @(posedge clk); #1; m1_ready = 1'b0;
        b0 = acc_cnt[0]; pb0 = pop_cnt[0];
        total[0] = sent[0] + 4;
        wait_acc(0, b0 + 4, "t4_acc0");
        wait_pop(0, pb0 + 4, "t4_pop0");
        chk("t4_q1_depth", q1.size(), 1);
        chk("t4_m1_valid_held", m1_valid, 1);
        if (q1.size() > 0) chk("t4_m1_y_held", m1_y, q1[0].y);
        @(posedge clk); #1; m1_ready = 1'b1;
        wait_drain("t4_drain");
        test = 0;

        // Reset two rows into a port 1 block with its output stalled.
        test = 5;
        @(posedge clk); #1; m1_ready = 1'b0;
        b1 = acc_cnt[1];
        total[1] = sent[1] + 4;
        wait_acc(1, b1 + 2, "t5_acc_pre");
        en[1] = 0;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        chk("t5_m0_valid", m0_valid, 0);
        chk("t5_m1_valid", m1_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_s1_ready", s1_ready, 0);
        @(posedge clk); #1; m1_ready = 1'b1;
        tick();
        ostart = order.size();
        b0 = acc_cnt[0]; b1 = acc_cnt[1];
        total[0] = sent[0] + 4; total[1] = sent[1] + 4;
        en[0] = 1; en[1] = 1;
        wait_acc(0, b0 + 4, "t5_acc0");
        wait_acc(1, b1 + 4, "t5_acc1");
        wait_drain("t5_drain");
        if (order.size() > ostart) chk("t5_first_grant", order[ostart], 0);
        else chk("t5_first_grant_seen", order.size(), ostart + 1);
        test = 0;

        // Port 0 gap of 3 cycles after row 1: grant held against port 1.
        test = 6; ostart = order.size();
        b0 = acc_cnt[0]; b1 = acc_cnt[1];
        total[0] = sent[0] + 4; total[1] = sent[1] + 4;
        wait_acc(0, b0 + 1, "t6_acc_row1");
        en[0] = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_s1_ready_gap", s1_ready, 0);
            chk("t6_port1_waiting", acc_cnt[1], b1);
        end
        en[0] = 1;
        wait_acc(0, b0 + 4, "t6_acc0");
        wait_acc(1, b1 + 4, "t6_acc1");
        wait_drain("t6_drain");
        chk("t6_block_count", order.size() - ostart, 2);
        if (order.size() >= ostart + 2) begin
            chk("t6_order_first", order[ostart], 0);
            chk("t6_order_second", order[ostart + 1], 1);
        end
        test = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
